// File: rtl/sd_pkg.sv
// Shared SD block constants and the write-path state encoding.
// The read path imports the same block size constants.
package sd_pkg;

  localparam int SD_BLOCK_BYTES = 512;
  localparam int SD_BLOCK_SHIFT = 9;

  typedef enum logic [2:0] {
    FILL,
    PAD,
    WAIT_RDY,
    ISSUE,
    STREAM,
    WAIT_DONE
  } sd_wr_state_t;

  // Byte address of block number blk; the sum wraps at 32 bits.
  function automatic logic [31:0] block_addr(input logic [31:0] base, input logic [22:0] blk);
    return base + {blk, {SD_BLOCK_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM. LOW_LATENCY gives one cycle of read latency;
// HIGH_PERFORMANCE adds an output register.
module xilinx_single_port_ram_read_first #(
  parameter int RAM_WIDTH       = 8,
  parameter int RAM_DEPTH       = 512,
  parameter     RAM_PERFORMANCE = "LOW_LATENCY"
) (
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         clka,
  input  logic                         wea,
  input  logic                         ena,
  output logic [RAM_WIDTH-1:0]         douta
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_q;

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      ram_q <= mem[addra];
    end
  end

  generate
    if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_out_reg
      always_ff @(posedge clka) begin
        if (ena) douta <= ram_q;
      end
    end else begin : g_no_reg
      assign douta = ram_q;
    end
  endgenerate

endmodule

// File: rtl/sd_block_writer.sv
// Collects input bytes into a 512-byte buffer and writes each full (or flushed,
// padded) block to sd_controller through its wr / ready_for_next_byte handshake.
module sd_block_writer
  import sd_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  axiid,
  input  logic        axiiv,
  output logic        axiir,
  input  logic        flush,
  input  logic        sd_ready,
  input  logic        sd_ready_for_next_byte,
  output logic        sd_wr,
  output logic [31:0] sd_addr,
  output logic [7:0]  sd_din,
  output logic        busy,
  output logic        block_done,
  output logic [15:0] blocks_written
);

  localparam logic [SD_BLOCK_SHIFT-1:0] LAST_BYTE = SD_BLOCK_SHIFT'(SD_BLOCK_BYTES - 1);

  sd_wr_state_t              state;
  logic [SD_BLOCK_SHIFT-1:0] wptr;
  logic [SD_BLOCK_SHIFT-1:0] rptr;
  logic [22:0]               blk;
  logic                      req_prev;
  logic                      req_rise;
  logic                      accept;
  logic [SD_BLOCK_SHIFT-1:0] ram_addr;
  logic                      ram_we;
  logic [7:0]                ram_wdata;
  logic [7:0]                ram_rdata;

  assign axiir    = (state == FILL);
  assign busy     = (state != FILL);
  assign accept   = axiiv && axiir;
  assign req_rise = sd_ready_for_next_byte && !req_prev;

  // The RAM output already tracks buf[rptr] (buf[0] from WAIT_RDY onward).
  assign sd_din = (state == ISSUE || state == STREAM) ? ram_rdata : 8'h00;

  // Fill and stream never overlap, so one RAM port is shared by both sides.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = axiid;
    case (state)
      FILL: begin
        ram_addr = wptr;
        ram_we   = accept;
      end
      PAD: begin
        ram_addr  = wptr;
        ram_we    = 1'b1;
        ram_wdata = PAD_BYTE;
      end
      STREAM:  ram_addr = rptr;
      default: ram_addr = '0;
    endcase
  end

  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH      (8),
    .RAM_DEPTH      (SD_BLOCK_BYTES),
    .RAM_PERFORMANCE("LOW_LATENCY")
  ) u_buf (
    .addra(ram_addr),
    .dina (ram_wdata),
    .clka (clk),
    .wea  (ram_we),
    .ena  (1'b1),
    .douta(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FILL;
      wptr           <= '0;
      rptr           <= '0;
      blk            <= '0;
      req_prev       <= 1'b0;
      sd_wr          <= 1'b0;
      sd_addr        <= '0;
      block_done     <= 1'b0;
      blocks_written <= '0;
    end else begin
      req_prev   <= sd_ready_for_next_byte;
      block_done <= 1'b0;
      case (state)
        FILL: begin
          // A byte arriving with flush is stored first; byte 511 swallows the flush.
          if (accept) begin
            wptr <= wptr + 1'b1;
            if (wptr == LAST_BYTE) state <= WAIT_RDY;
            else if (flush)        state <= PAD;
          end else if (flush && wptr != '0) begin
            state <= PAD;
          end
        end
        PAD: begin
          wptr <= wptr + 1'b1;
          if (wptr == LAST_BYTE) state <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (sd_ready) begin
            sd_wr   <= 1'b1;
            sd_addr <= block_addr(BASE_ADDR, blk);
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (!sd_ready) begin
            sd_wr <= 1'b0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (req_rise) begin
            rptr <= rptr + 1'b1;
            if (rptr == LAST_BYTE) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (sd_ready) begin
            blk            <= blk + 23'd1;
            blocks_written <= blocks_written + 16'd1;
            block_done     <= 1'b1;
            wptr           <= '0;
            rptr           <= '0;
            state          <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_writer.sv
// Directed bench for sd_block_writer with a behavioral sd_controller write model
// that records every byte it is handed.
module tb_sd_block_writer;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [7:0]  PADB = 8'h5A;

  logic        clk;
  logic        rst_n;
  logic [7:0]  axiid;
  logic        axiiv;
  logic        axiir;
  logic        flush;
  logic        sd_ready;
  logic        sd_rfnb;
  logic        sd_wr;
  logic [31:0] sd_addr;
  logic [7:0]  sd_din;
  logic        busy;
  logic        block_done;
  logic [15:0] blocks_written;

  int total;
  int bad;

  logic [8:0] tx_mem [4096];
  int         tx_head;
  int         tx_tail;
  int         flush_req;
  int         flush_ack;

  logic [7:0]  cap [4096];
  int          cap_count;
  int          cap_base;
  int          m_state;
  int          m_cnt;
  int          m_pulses;
  int          cycle;
  int          bursts;
  int          wr_rise_cycle;
  int          busy_rise_cycle;
  int          busy_cycles;
  int          done_cnt;
  int          stream_axiir_err;
  logic [31:0] last_addr;
  logic        wr_prev;
  logic        busy_prev;

  sd_block_writer #(
    .BASE_ADDR(BASE),
    .PAD_BYTE (PADB)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .axiid                 (axiid),
    .axiiv                 (axiiv),
    .axiir                 (axiir),
    .flush                 (flush),
    .sd_ready              (sd_ready),
    .sd_ready_for_next_byte(sd_rfnb),
    .sd_wr                 (sd_wr),
    .sd_addr               (sd_addr),
    .sd_din                (sd_din),
    .busy                  (busy),
    .block_done            (block_done),
    .blocks_written        (blocks_written)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte patterns; kind 2 is AA BB CC followed by pad bytes.
  function automatic logic [7:0] genByte(input int kind, input int i);
    case (kind)
      0:       return 8'(i);
      1:       return 8'(i * 3 + 7);
      2:       return (i == 0) ? 8'hAA : (i == 1) ? 8'hBB : (i == 2) ? 8'hCC : PADB;
      3:       return 8'(i) ^ 8'hC3;
      default: return 8'(i) ^ 8'hA5;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int kind, input int count, input bit flush_last);
    for (int i = 0; i < count; i++) begin
      tx_mem[tx_tail] = {flush_last && (i == count - 1), genByte(kind, i)};
      tx_tail++;
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitBlocks(input logic [15:0] target, input string tag);
    int n;
    n = 0;
    while (blocks_written !== target && n < 15000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done"}, blocks_written, target);
    waitCycles(2);
  endtask

  task automatic checkBlock(input string tag, input int kind, input logic [31:0] addr,
                            input logic [15:0] count_exp);
    int mism;
    mism = 0;
    checkOutput({tag, "_len"}, cap_count - cap_base, 512);
    for (int i = 0; i < 512; i++) begin
      if (cap[cap_base + i] !== genByte(kind, i)) mism++;
    end
    checkOutput({tag, "_bad_bytes"}, mism, 0);
    checkOutput({tag, "_addr"}, last_addr, addr);
    checkOutput({tag, "_count"}, blocks_written, count_exp);
    cap_base = cap_count;
  endtask

  // Byte producer: presents the next queued byte and pops it when axiir is high.
  initial begin
    axiiv = 1'b0;
    axiid = 8'h00;
    flush = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_head = tx_tail;
        axiiv   = 1'b0;
        flush   = 1'b0;
      end else begin
        flush = 1'b0;
        if (flush_req != flush_ack) begin
          flush = 1'b1;
          flush_ack++;
        end
        if (tx_head != tx_tail) begin
          axiiv = 1'b1;
          axiid = tx_mem[tx_head][7:0];
          if (axiir) begin
            if (tx_mem[tx_head][8]) flush = 1'b1;
            tx_head++;
          end
        end else begin
          axiiv = 1'b0;
        end
      end
    end
  end

  // sd_controller write model plus observation counters.
  initial begin
    sd_ready = 1'b1;
    sd_rfnb  = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      if (sd_wr && !wr_prev) begin
        bursts++;
        wr_rise_cycle = cycle;
      end
      wr_prev = sd_wr;
      if (busy && !busy_prev) busy_rise_cycle = cycle;
      busy_prev = busy;
      if (busy) busy_cycles++;
      if (block_done) done_cnt++;
      if (!rst_n) begin
        sd_ready = 1'b1;
        sd_rfnb  = 1'b0;
        m_state  = 0;
        m_cnt    = 0;
        m_pulses = 0;
      end else begin
        case (m_state)
          0: if (sd_wr) begin
               last_addr = sd_addr;
               m_cnt     = 0;
               m_state   = 1;
             end
          1: begin
               m_cnt++;
               if (m_cnt == 2) begin
                 sd_ready = 1'b0;
                 m_cnt    = 0;
                 m_pulses = 0;
                 m_state  = 2;
               end
             end
          2: begin
               if (axiir) stream_axiir_err++;
               sd_rfnb = 1'b0;
               m_cnt++;
               if (m_cnt == 20) begin
                 cap[cap_count] = sd_din;
                 cap_count++;
                 sd_rfnb = 1'b1;
                 m_cnt   = 0;
                 m_pulses++;
                 if (m_pulses == 512) m_state = 3;
               end
             end
          default: begin
               sd_rfnb = 1'b0;
               m_cnt++;
               if (m_cnt == 30) begin
                 sd_ready = 1'b1;
                 m_state  = 0;
               end
             end
        endcase
      end
    end
  end

  initial begin
    int n;
    int b0;
    int w0;
    rst_n     = 1'b1;
    flush_req = 0;
    #2 rst_n  = 1'b0;
    waitCycles(3);
    checkOutput("rst_sd_wr", sd_wr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sd_addr", sd_addr, 0);
    checkOutput("rst_sd_din", sd_din, 0);
    checkOutput("rst_block_done", block_done, 0);
    checkOutput("rst_blocks_written", blocks_written, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("axiir_after_reset", axiir, 1);

    $display("[TB] full block then second block, back to back");
    applyStimulus(0, 512, 0);
    applyStimulus(1, 512, 0);
    waitBlocks(1, "blk0");
    checkBlock("blk0", 0, BASE, 1);
    checkOutput("blk0_bursts", bursts, 1);
    checkOutput("blk0_done_pulses", done_cnt, 1);
    waitBlocks(2, "blk1");
    checkBlock("blk1", 1, BASE + 32'd512, 2);
    checkOutput("blk1_bursts", bursts, 2);
    checkOutput("stream_axiir_low", stream_axiir_err, 0);
    checkOutput("tx_drained", tx_tail - tx_head, 0);

    $display("[TB] flush coincident with byte 511");
    applyStimulus(3, 512, 1);
    waitBlocks(3, "coinc");
    checkBlock("coinc", 3, BASE + 32'd1024, 3);
    checkOutput("coinc_bursts", bursts, 3);

    $display("[TB] flush of a 3-byte partial block, flush during STREAM");
    applyStimulus(2, 3, 0);
    n = 0;
    while (tx_head != tx_tail && n < 100) begin
      @(negedge clk);
      n++;
    end
    waitCycles(2);
    flush_req++;
    n = 0;
    while (bursts < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pad_to_wr_cycles", wr_rise_cycle - busy_rise_cycle, 510);
    n = 0;
    while (!(m_state == 2 && m_pulses >= 50) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    flush_req++;
    waitBlocks(4, "pad");
    checkBlock("pad", 2, BASE + 32'd1536, 4);
    checkOutput("pad_bursts", bursts, 4);

    $display("[TB] flush with empty buffer");
    b0 = busy_cycles;
    w0 = bursts;
    flush_req++;
    waitCycles(40);
    checkOutput("empty_flush_busy", busy_cycles - b0, 0);
    checkOutput("empty_flush_wr", bursts - w0, 0);
    checkOutput("done_pulses_total", done_cnt, 4);

    $display("[TB] reset in the middle of STREAM");
    applyStimulus(4, 512, 0);
    n = 0;
    while (!(m_state == 2 && m_pulses >= 100) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_sd_wr", sd_wr, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_blocks_written", blocks_written, 0);
    checkOutput("midrst_sd_addr", sd_addr, 0);
    waitCycles(2);
    rst_n = 1'b1;
    @(negedge clk);
    cap_base = cap_count;
    applyStimulus(4, 512, 0);
    waitBlocks(1, "post_rst");
    checkBlock("post_rst", 4, BASE, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
